// File: rtl/ssd_scan_mux.sv
// Multi-digit seven-segment scanner with frame-synchronous shadow loading,
// leading-zero suppression, per-digit blanking/decimal points and PWM brightness.
module ssd_scan_mux #(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned SCAN_DIV_W = 14,
    parameter int unsigned BRIGHT_W   = 3
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic [N_DIGITS-1:0]     An,
    output logic [7:0]              Cath,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [SCAN_DIV_W-1:0] r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_digits;
    logic [N_DIGITS-1:0]   r_dp;
    logic [N_DIGITS-1:0]   r_blank;
    logic                  r_lz;
    logic                  r_pending;
    logic                  r_loaded;
    logic [N_DIGITS-1:0]   r_an;
    logic [7:0]            r_cath;

    logic                  w_presc_max;
    logic                  w_last;
    logic                  w_capture;
    logic [N_DIGITS-1:0]   w_supp;
    logic                  w_run;
    logic [3:0]            w_cur_digit;
    logic [BRIGHT_W-1:0]   w_phase;
    logic                  w_dark;
    logic [6:0]            w_seg;
    logic [N_DIGITS-1:0]   w_an_d;
    logic [7:0]            w_cath_d;

    assign w_presc_max = &r_presc;
    assign w_last      = (r_idx == IDX_W'(N_DIGITS - 1));
    assign frame_done  = w_presc_max && w_last;
    assign w_capture   = frame_done && (r_pending || load);
    assign w_cur_digit = r_digits[{r_idx, 2'b00} +: 4];
    assign w_phase     = r_presc[SCAN_DIV_W-1 -: BRIGHT_W];

    // Walk down from the most significant digit while every digit seen is zero.
    always_comb begin
        w_run  = 1'b1;
        w_supp = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            w_run     = w_run & (r_digits[4*k +: 4] == 4'h0);
            w_supp[k] = r_lz & w_run & (k != 0);
        end
    end

    always_comb begin
        w_seg = 7'h7F;
        case (w_cur_digit)
            4'h0: w_seg = 7'h01;
            4'h1: w_seg = 7'h4F;
            4'h2: w_seg = 7'h12;
            4'h3: w_seg = 7'h06;
            4'h4: w_seg = 7'h4C;
            4'h5: w_seg = 7'h24;
            4'h6: w_seg = 7'h20;
            4'h7: w_seg = 7'h0F;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h04;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h60;
            4'hC: w_seg = 7'h31;
            4'hD: w_seg = 7'h42;
            4'hE: w_seg = 7'h30;
            4'hF: w_seg = 7'h38;
            default: w_seg = 7'h7F;
        endcase
    end

    always_comb begin
        w_dark   = r_blank[r_idx] | (w_supp[r_idx] & ~r_dp[r_idx]);
        w_an_d   = '1;
        w_cath_d = 8'hFF;
        // Prescaler zero is a dead-band slot so the previous digit never ghosts onto the next.
        if (r_loaded && !w_dark && (r_presc != '0) && (w_phase <= brightness)) begin
            w_an_d[r_idx] = 1'b0;
        end
        if (r_loaded && !r_blank[r_idx]) begin
            w_cath_d = {(w_supp[r_idx] ? 7'h7F : w_seg), ~r_dp[r_idx]};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_digits  <= '0;
            r_dp      <= '0;
            r_blank   <= '0;
            r_lz      <= 1'b0;
            r_pending <= 1'b0;
            r_loaded  <= 1'b0;
            r_an      <= '1;
            r_cath    <= 8'hFF;
        end else begin
            r_presc <= r_presc + SCAN_DIV_W'(1);
            if (w_presc_max) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
            if (w_capture) begin
                r_digits  <= digits_in;
                r_dp      <= dp_in;
                r_blank   <= blank_in;
                r_lz      <= lz_suppress;
                r_loaded  <= 1'b1;
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
            r_an   <= w_an_d;
            r_cath <= w_cath_d;
        end
    end

    assign An   = r_an;
    assign Cath = r_cath;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux: cycle-level reference model plus directed
// scenarios with hand-computed per-frame expectations and a randomized phase.
module tb_ssd_scan_mux;

    localparam int ND = 4;
    localparam int SW = 4;
    localparam int BW = 2;
    localparam int SLOT = 16;
    localparam int FRAME = 64;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic          lz_suppress = 1'b0;
    logic [1:0]    brightness = '0;
    logic          load = 1'b0;
    logic [3:0]    An;
    logic [7:0]    Cath;
    logic          frame_done;

    always #5 Clk = ~Clk;

    ssd_scan_mux #(
        .N_DIGITS   (ND),
        .SCAN_DIV_W (SW),
        .BRIGHT_W   (BW)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .load        (load),
        .An          (An),
        .Cath        (Cath),
        .frame_done  (frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: position in the scan is pure arithmetic on the cycle count.
    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    int         t;
    logic [3:0] m_dig [ND];
    logic [3:0] m_dp, m_blank;
    logic       m_lz, m_pend, m_loaded;
    logic [3:0] exp_an = 4'hF;
    logic [7:0] exp_cath = 8'hFF;
    logic       exp_cv = 1'b1;
    logic       exp_fd = 1'b0;

    task automatic model_step();
        int  presc, idx;
        bit  supp, dark, lit, fd;
        if (!Reset_n) begin
            t = 0; m_pend = 0; m_loaded = 0; m_lz = 0; m_dp = '0; m_blank = '0;
            for (int j = 0; j < ND; j++) m_dig[j] = '0;
            exp_an = 4'hF; exp_cath = 8'hFF; exp_cv = 1'b1; exp_fd = 1'b0;
            return;
        end
        presc = t % SLOT;
        idx   = (t / SLOT) % ND;
        fd    = (presc == SLOT - 1) && (idx == ND - 1);
        if (!m_loaded) begin
            exp_an = 4'hF; exp_cath = 8'hFF; exp_cv = 1'b1;
        end else begin
            supp = m_lz && (idx != 0);
            for (int j = idx; j < ND; j++) if (m_dig[j] != 0) supp = 0;
            dark = m_blank[idx] || (supp && !m_dp[idx]);
            lit  = !dark && (presc != 0) && ((presc / 4) <= int'(brightness));
            exp_an   = lit ? ~(4'b0001 << idx) : 4'hF;
            exp_cath = {(supp ? 7'h7F : seg_tab[m_dig[idx]]), ~m_dp[idx]};
            exp_cv   = lit;
        end
        if (fd && (m_pend || load)) begin
            for (int j = 0; j < ND; j++) m_dig[j] = digits_in[4*j +: 4];
            m_dp = dp_in; m_blank = blank_in; m_lz = lz_suppress;
            m_loaded = 1; m_pend = 0;
        end else if (load) begin
            m_pend = 1;
        end
        t++;
        exp_fd = ((t % SLOT) == SLOT - 1) && (((t / SLOT) % ND) == ND - 1);
    endtask

    always @(posedge Clk or negedge Reset_n) model_step();

    always @(negedge Clk) begin
        if (chk_en) begin
            check("an", int'(An), int'(exp_an));
            check("frame_done", int'(frame_done), int'(exp_fd));
            if (exp_cv) check("cath", int'(Cath), int'(exp_cath));
        end
    end

    int         cnt [ND];
    logic [7:0] wc  [ND];

    task automatic pulse_load();
        load = 1'b1;
        @(negedge Clk);
        load = 1'b0;
    endtask

    task automatic wait_fd();
        bit seen = 0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge Clk);
            if (frame_done) seen = 1;
        end
        if (!seen) check("wait_fd timeout", 0, 1);
    endtask

    // Called on a frame_done negedge; tallies the whole following frame.
    task automatic window();
        @(negedge Clk);
        load = 1'b0;
        for (int k = 0; k < ND; k++) begin cnt[k] = 0; wc[k] = 8'hFF; end
        repeat (FRAME) begin
            @(negedge Clk);
            #1;
            for (int k = 0; k < ND; k++) if (!An[k]) begin cnt[k]++; wc[k] = Cath; end
        end
    endtask

    initial begin
        int fd_cnt, low_cnt;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        chk_en  = 1'b1;

        // No load yet: dark, frame_done every 64 cycles.
        fd_cnt = 0; low_cnt = 0;
        repeat (200) begin
            @(negedge Clk); #1;
            fd_cnt += int'(frame_done);
            if (An != 4'hF) low_cnt++;
        end
        check("t1 fd pulses", fd_cnt, 3);
        check("t1 dark", low_cnt, 0);

        digits_in = 16'h12A0; dp_in = 4'b0010; brightness = 2'd3;
        pulse_load();
        wait_fd(); window();
        check("t2 d0 cath", int'(wc[0]), 8'h03);
        check("t2 d1 cath", int'(wc[1]), 8'h10);
        check("t2 d2 cath", int'(wc[2]), 8'h25);
        check("t2 d3 cath", int'(wc[3]), 8'h9F);
        for (int k = 0; k < ND; k++) check("t2 on cycles", cnt[k], 15);

        lz_suppress = 1'b1; digits_in = 16'h0050; dp_in = 4'b0000;
        pulse_load();
        wait_fd(); window();
        check("t3 d3 dark", cnt[3], 0);
        check("t3 d2 dark", cnt[2], 0);
        check("t3 d1 on", cnt[1], 15);
        check("t3 d1 cath", int'(wc[1]), 8'h49);
        check("t3 d0 cath", int'(wc[0]), 8'h03);
        digits_in = 16'h0000;
        pulse_load();
        wait_fd(); window();
        check("t3 zero d1 dark", cnt[1], 0);
        check("t3 zero d0 on", cnt[0], 15);

        digits_in = 16'h0077;
        wait_fd(); window();
        check("t4 no load d1", cnt[1], 0);
        check("t4 no load d0", int'(wc[0]), 8'h03);
        wait_fd();
        repeat (10) @(negedge Clk);
        digits_in = 16'h0008;
        pulse_load();
        wait_fd(); window();
        check("t4 mid load d0", int'(wc[0]), 8'h01);
        wait_fd();
        digits_in = 16'h0009;
        load = 1'b1;
        window();
        check("t4 fd load d0", int'(wc[0]), 8'h09);

        lz_suppress = 1'b0; digits_in = 16'h1234; brightness = 2'd0;
        pulse_load();
        wait_fd(); window();
        for (int k = 0; k < ND; k++) check("t5 b0 on cycles", cnt[k], 3);
        brightness = 2'd1;
        wait_fd(); window();
        for (int k = 0; k < ND; k++) check("t5 b1 on cycles", cnt[k], 7);
        blank_in = 4'b0100;
        pulse_load();
        wait_fd(); window();
        check("t5 blank d2", cnt[2], 0);
        check("t5 blank d0", cnt[0], 7);

        digits_in = 16'h5678;
        pulse_load();
        repeat (5) @(negedge Clk);
        @(posedge Clk); #3;
        Reset_n = 1'b0;
        #1;
        check("t6 reset an", int'(An), 4'hF);
        check("t6 reset cath", int'(Cath), 8'hFF);
        @(negedge Clk);
        Reset_n = 1'b1;
        low_cnt = 0;
        repeat (150) begin @(negedge Clk); #1; if (An != 4'hF) low_cnt++; end
        check("t6 dark after reset", low_cnt, 0);
        pulse_load();
        wait_fd(); window();
        check("t6 reload d0", cnt[0], 7);
        check("t6 reload d0 cath", int'(wc[0]), 8'h01);

        // Randomized phase against the model.
        repeat (3000) begin
            @(negedge Clk);
            load = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                digits_in   = 16'($urandom);
                dp_in       = 4'($urandom);
                blank_in    = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
                lz_suppress = 1'($urandom);
                if ($urandom_range(0, 3) == 0) digits_in[15:8] = 8'h00;
            end
            if ($urandom_range(0, 49) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 39) == 0) load = 1'b1;
        end
        load = 1'b0;
        @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
